// File: rtl/freq_multi_scan_pkg.sv
// Shared definitions for the multi-block frequency readout engine:
// FSM states, flag bit positions and the {block, channel} flattening rule.
package freq_multi_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CHECK,
    S_EMIT
  } state_t;

  localparam int FLAG_LO = 0;
  localparam int FLAG_HI = 1;
  localparam int FLAG_W  = 2;

  // Alarm and limit storage are dense: index = block*NF + channel.
  function automatic int flat_index(input int blk, input int chan, input int nf);
    return blk * nf + chan;
  endfunction

endpackage

// File: rtl/freq_multi_scan_limits.sv
// Per-channel min/max limit register file: one synchronous write port,
// one combinational read port; writes to non-existent channels are ignored.
module freq_multi_scan_limits
  import freq_multi_scan_pkg::*;
#(
  parameter int NF = 8,
  parameter int NG = 1,
  parameter int uw = 28,
  parameter int NA = 3,
  parameter int AW = 3,
  parameter int IW = 3
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          we_i,
  input  logic          sel_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [uw-1:0] wdata_i,
  input  logic [IW-1:0] ridx_i,
  output logic [uw-1:0] min_o,
  output logic [uw-1:0] max_o
);

  localparam int NT = NF * NG;

  logic [uw-1:0] min_q [NT];
  logic [uw-1:0] max_q [NT];

  int   wblk;
  int   wchan;
  int   widx;
  logic wvalid;

  always_comb begin
    wblk   = int'(32'(waddr_i) >> NA);
    wchan  = int'(waddr_i[NA-1:0]);
    widx   = flat_index(wblk, wchan, NF);
    wvalid = we_i && (wchan < NF) && (wblk < NG);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NT; i++) begin
        min_q[i] <= '0;
        max_q[i] <= '1;
      end
    end else if (wvalid) begin
      if (sel_i) max_q[widx] <= wdata_i;
      else       min_q[widx] <= wdata_i;
    end
  end

  assign min_o = min_q[ridx_i];
  assign max_o = max_q[ridx_i];

endmodule

// File: rtl/freq_multi_scan.sv
// Readout engine: on each source_state change, reads the finished channel from
// every counter block, limit-checks it and emits one valid/ready beat per block.
module freq_multi_scan
  import freq_multi_scan_pkg::*;
#(
  parameter int NF  = 8,
  parameter int NG  = 1,
  parameter int cw  = 3,
  parameter int uw  = 28,
  parameter int NA_ = $clog2(NF),
  parameter int NB_ = $clog2(NG)
) (
  input  logic                 refclk,
  input  logic                 reset,
  input  logic [NA_+cw-1:0]    source_state,
  output logic [NB_+NA_-1:0]   addr,
  input  logic [uw-1:0]        frequency,
  input  logic                 lim_we,
  input  logic                 lim_sel,
  input  logic [NB_+NA_-1:0]   lim_addr,
  input  logic [uw-1:0]        lim_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NB_+NA_-1:0]   out_chan,
  output logic [uw-1:0]        out_freq,
  output logic                 out_lo,
  output logic                 out_hi,
  output logic [NF*NG-1:0]     alarm,
  input  logic                 alarm_clr,
  output logic                 overrun,
  output logic                 busy
);

  localparam int AW = NB_ + NA_;
  localparam int SW = NA_ + cw;
  localparam int NT = NF * NG;
  localparam int IW = $clog2(NT);
  localparam int BW = (NB_ > 0) ? NB_ : 1;

  logic [SW-1:0]     ss_prev_q;
  state_t            state_q, state_d;
  logic [NA_-1:0]    fc_q, fc_d;
  logic [BW-1:0]     b_q, b_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              out_valid_q, out_valid_d;
  logic [AW-1:0]     out_chan_q, out_chan_d;
  logic [uw-1:0]     out_freq_q, out_freq_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [NT-1:0]     alarm_q, alarm_d;
  logic              overrun_q, overrun_d;

  logic              change;
  logic [AW-1:0]     cur_chan;
  logic [IW-1:0]     cur_idx;
  logic [uw-1:0]     lim_min, lim_max;
  logic              f_lo, f_hi;

  assign change   = (source_state != ss_prev_q);
  assign cur_chan = (AW'(b_q) << NA_) | AW'(fc_q);
  assign cur_idx  = IW'(flat_index(int'(b_q), int'(fc_q), NF));
  assign f_lo     = (frequency < lim_min);
  assign f_hi     = (frequency > lim_max);

  freq_multi_scan_limits #(
    .NF(NF), .NG(NG), .uw(uw), .NA(NA_), .AW(AW), .IW(IW)
  ) u_limits (
    .clk_i   (refclk),
    .reset_i (reset),
    .we_i    (lim_we),
    .sel_i   (lim_sel),
    .waddr_i (lim_addr),
    .wdata_i (lim_data),
    .ridx_i  (cur_idx),
    .min_o   (lim_min),
    .max_o   (lim_max)
  );

  always_comb begin
    state_d     = state_q;
    fc_d        = fc_q;
    b_d         = b_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    out_freq_d  = out_freq_q;
    flags_d     = flags_q;
    alarm_d     = alarm_clr ? '0 : alarm_q;
    overrun_d   = alarm_clr ? 1'b0 : overrun_q;
    // A change mid-scan is dropped; the scan in progress is left untouched.
    if (change && (state_q != S_IDLE)) overrun_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (change) begin
          fc_d    = ss_prev_q[NA_-1:0];
          b_d     = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        addr_d  = cur_chan;
        state_d = S_WAIT;
      end
      S_WAIT: state_d = S_CHECK;
      S_CHECK: begin
        out_chan_d       = cur_chan;
        out_freq_d       = frequency;
        flags_d[FLAG_LO] = f_lo;
        flags_d[FLAG_HI] = f_hi;
        out_valid_d      = 1'b1;
        if (f_lo || f_hi) alarm_d[cur_idx] = 1'b1;
        state_d          = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (b_q == BW'(NG - 1)) begin
            state_d = S_IDLE;
          end else begin
            b_d     = b_q + BW'(1);
            state_d = S_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Previous state tracks the input even through reset, so reset never
  // manufactures a change.
  always_ff @(posedge refclk) begin
    ss_prev_q <= source_state;
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fc_q        <= '0;
      b_q         <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_freq_q  <= '0;
      flags_q     <= '0;
      alarm_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      b_q         <= b_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_freq_q  <= out_freq_d;
      flags_q     <= flags_d;
      alarm_q     <= alarm_d;
      overrun_q   <= overrun_d;
    end
  end

  assign addr      = addr_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_freq  = out_freq_q;
  assign out_lo    = flags_q[FLAG_LO];
  assign out_hi    = flags_q[FLAG_HI];
  assign alarm     = alarm_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_multi_scan.sv
// Bench: an NF=8/NG=2 instance checked against a limit/alarm reference model,
// plus an NF=6/NG=1 instance for the non-power-of-two channel wrap.
module tb_freq_multi_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [5:0]  ss_a;
  logic [3:0]  addr_a;
  logic [27:0] freq_a;
  logic        lim_we, lim_sel;
  logic [3:0]  lim_addr;
  logic [27:0] lim_data;
  logic        out_valid_a, out_ready_a, out_lo_a, out_hi_a;
  logic [3:0]  out_chan_a;
  logic [27:0] out_freq_a;
  logic [15:0] alarm_a;
  logic        alarm_clr_a, overrun_a, busy_a;

  logic [5:0]  ss_b;
  logic [2:0]  addr_b, out_chan_b;
  logic [27:0] freq_b, out_freq_b;
  logic        out_valid_b, out_ready_b, out_lo_b, out_hi_b, overrun_b, busy_b;
  logic [5:0]  alarm_b;

  freq_multi_scan #(.NF(8), .NG(2), .cw(3), .uw(28)) dut_a (
    .refclk(clk), .reset(reset), .source_state(ss_a), .addr(addr_a),
    .frequency(freq_a), .lim_we(lim_we), .lim_sel(lim_sel),
    .lim_addr(lim_addr), .lim_data(lim_data), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_chan(out_chan_a), .out_freq(out_freq_a),
    .out_lo(out_lo_a), .out_hi(out_hi_a), .alarm(alarm_a),
    .alarm_clr(alarm_clr_a), .overrun(overrun_a), .busy(busy_a)
  );

  freq_multi_scan #(.NF(6), .NG(1), .cw(3), .uw(28)) dut_b (
    .refclk(clk), .reset(reset), .source_state(ss_b), .addr(addr_b),
    .frequency(freq_b), .lim_we(1'b0), .lim_sel(1'b0),
    .lim_addr(3'd0), .lim_data(28'd0), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_chan(out_chan_b), .out_freq(out_freq_b),
    .out_lo(out_lo_b), .out_hi(out_hi_b), .alarm(alarm_b),
    .alarm_clr(1'b0), .overrun(overrun_b), .busy(busy_b)
  );

  // Counter RAM models: read data valid one cycle after addr.
  logic [27:0] mem_a [16];
  logic [27:0] mem_b [8];
  always @(posedge clk) begin
    freq_a <= mem_a[addr_a];
    freq_b <= mem_b[addr_b];
  end

  logic [27:0] mdl_min [16];
  logic [27:0] mdl_max [16];
  logic [15:0] mdl_alarm;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0]  obs_chan [2];
  logic [27:0] obs_freq [2];
  logic        obs_lo [2];
  logic        obs_hi [2];
  int          obs_n;
  int          obs_lat;
  logic        obs_stable;

  function automatic logic [15:0] viol_mask(input int fc);
    logic [15:0] m;
    m = '0;
    for (int b = 0; b < 2; b++) begin
      int i;
      i = b * 8 + fc;
      if (mem_a[i] < mdl_min[i] || mem_a[i] > mdl_max[i]) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mdl_min[i] = '0;
      mdl_max[i] = '1;
    end
    mdl_alarm = '0;
  endtask

  task automatic lim_write(input logic sel, input logic [3:0] a, input logic [27:0] d);
    @(negedge clk);
    lim_we = 1'b1; lim_sel = sel; lim_addr = a; lim_data = d;
    @(negedge clk);
    lim_we = 1'b0;
    if (sel) mdl_max[a] = d;
    else     mdl_min[a] = d;
  endtask

  task automatic pulse_clr();
    @(negedge clk); alarm_clr_a = 1'b1;
    @(negedge clk); alarm_clr_a = 1'b0;
    @(negedge clk);
  endtask

  // Change source_state, then collect both beats under random backpressure.
  // Optional alarm_clr / limit write are driven during the first CHECK cycle.
  task automatic run_scan(input logic [5:0] new_ss, input int stall_pct,
                          input logic clr3, input logic lw3, input logic lw_s,
                          input logic [3:0] lw_a, input logic [27:0] lw_d);
    logic pv, pr;
    int cyc;
    @(negedge clk);
    ss_a = new_ss; out_ready_a = 1'b0;
    pv = 1'b0; pr = 1'b0; cyc = 0;
    obs_n = 0; obs_lat = -1; obs_stable = 1'b1;
    while (obs_n < 2 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (pv && pr) obs_n++;
      alarm_clr_a = 1'b0; lim_we = 1'b0;
      if (cyc == 3) begin
        alarm_clr_a = clr3;
        if (lw3) begin
          lim_we = 1'b1; lim_sel = lw_s; lim_addr = lw_a; lim_data = lw_d;
        end
      end
      if (obs_n < 2 && out_valid_a) begin
        if (obs_lat < 0) obs_lat = cyc;
        if (pv && !pr) begin
          if (out_chan_a !== obs_chan[obs_n] || out_freq_a !== obs_freq[obs_n] ||
              out_lo_a !== obs_lo[obs_n] || out_hi_a !== obs_hi[obs_n])
            obs_stable = 1'b0;
        end else begin
          obs_chan[obs_n] = out_chan_a; obs_freq[obs_n] = out_freq_a;
          obs_lo[obs_n]   = out_lo_a;   obs_hi[obs_n]   = out_hi_a;
        end
      end
      pr = ($urandom_range(99) >= stall_pct);
      out_ready_a = pr;
      pv = out_valid_a;
    end
    out_ready_a = 1'b0; alarm_clr_a = 1'b0; lim_we = 1'b0;
    n_chk++;
    if (obs_n < 2) begin
      n_fail++;
      $display("FAIL scan_timeout: beats=%0d required=2", obs_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (addr_a !== 4'd0) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", addr_a); end
    n_chk++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid_a); end
    n_chk++; if ({out_chan_a, out_freq_a, out_lo_a, out_hi_a} !== '0) begin n_fail++; $display("FAIL rst_outdata: chan=%0h freq=%0h lo=%b hi=%b want 0", out_chan_a, out_freq_a, out_lo_a, out_hi_a); end
    n_chk++; if (alarm_a !== 16'h0) begin n_fail++; $display("FAIL rst_alarm: got %h want 0", alarm_a); end
    n_chk++; if (overrun_a !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun_a); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    n_chk++; if (out_valid_b !== 1'b0 || alarm_b !== 6'h0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL rst_dut_b: valid=%b alarm=%h busy=%b want 0", out_valid_b, alarm_b, busy_b); end
  endtask

  task automatic test_basic();
    mem_a[5] = 28'd1000; mem_a[13] = 28'd2000;
    run_scan(6'h06, 0, 1'b0, 1'b0, 1'b0, 4'd0, 28'd0);
    n_chk++; if (obs_lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", obs_lat); end
    n_chk++; if (obs_chan[0] !== 4'd5 || obs_chan[1] !== 4'd13) begin n_fail++; $display("FAIL basic_chan: got %0d,%0d want 5,13", obs_chan[0], obs_chan[1]); end
    n_chk++; if (obs_freq[0] !== 28'd1000 || obs_freq[1] !== 28'd2000) begin n_fail++; $display("FAIL basic_freq: got %0d,%0d want 1000,2000", obs_freq[0], obs_freq[1]); end
    n_chk++; if ({obs_lo[0], obs_hi[0], obs_lo[1], obs_hi[1]} !== 4'b0) begin n_fail++; $display("FAIL basic_flags: got %b%b%b%b want 0000", obs_lo[0], obs_hi[0], obs_lo[1], obs_hi[1]); end
    @(negedge clk);
    n_chk++; if (busy_a !== 1'b0 || alarm_a !== 16'h0) begin n_fail++; $display("FAIL basic_idle: busy=%b alarm=%h want 0,0", busy_a, alarm_a); end
  endtask

  task automatic test_limits();
    lim_write(1'b0, 4'd3, 28'd500);
    lim_write(1'b1, 4'd3, 28'd600);
    mem_a[3] = 28'd700; mem_a[11] = 28'd100;
    run_scan(6'h0B, 0, 1'b0, 1'b0, 1'b0, 4'd0, 28'd0);
    mdl_alarm |= viol_mask(6);
    run_scan(6'h0C, 30, 1'b0, 1'b0, 1'b0, 4'd0, 28'd0);
    mdl_alarm |= viol_mask(3);
    n_chk++; if (obs_chan[0] !== 4'd3 || obs_hi[0] !== 1'b1 || obs_lo[0] !== 1'b0) begin n_fail++; $display("FAIL lim_hi_flag: chan=%0d hi=%b lo=%b want 3,1,0", obs_chan[0], obs_hi[0], obs_lo[0]); end
    n_chk++; if (obs_hi[1] !== 1'b0 || obs_lo[1] !== 1'b0) begin n_fail++; $display("FAIL lim_blk1_flags: hi=%b lo=%b want 0,0", obs_hi[1], obs_lo[1]); end
    n_chk++; if (alarm_a !== 16'h0008 || alarm_a !== mdl_alarm) begin n_fail++; $display("FAIL lim_alarm_set: got %h want %h", alarm_a, mdl_alarm); end
    pulse_clr();
    mdl_alarm = '0;
    n_chk++; if (alarm_a !== 16'h0) begin n_fail++; $display("FAIL lim_alarm_clr: got %h want 0", alarm_a); end
    lim_write(1'b1, 4'd12, 28'd10);
    mem_a[12] = 28'd50; mem_a[4] = 28'd0;
    run_scan(6'h0B, 0, 1'b0, 1'b0, 1'b0, 4'd0, 28'd0);
    n_chk++; if (alarm_a !== 16'h1000) begin n_fail++; $display("FAIL lim_alarm_other: got %h want 1000", alarm_a); end
    run_scan(6'h0C, 0, 1'b1, 1'b0, 1'b0, 4'd0, 28'd0);
    mdl_alarm = 16'h0008;
    n_chk++; if (alarm_a !== 16'h0008) begin n_fail++; $display("FAIL lim_clr_vs_set: got %h want 0008", alarm_a); end
  endtask

  task automatic test_lim_write_during_check();
    lim_write(1'b0, 4'd2, 28'd0);
    lim_write(1'b1, 4'd2, 28'd100);
    mem_a[2] = 28'd500;
    run_scan(6'h0A, 0, 1'b0, 1'b0, 1'b0, 4'd0, 28'd0);
    mdl_alarm |= viol_mask(4);
    run_scan(6'h0B, 0, 1'b0, 1'b1, 1'b1, 4'd2, 28'd1000);
    mdl_alarm |= viol_mask(2);
    mdl_max[2] = 28'd1000;
    n_chk++; if (obs_chan[0] !== 4'd2 || obs_hi[0] !== 1'b1) begin n_fail++; $display("FAIL lwc_old_limit: chan=%0d hi=%b want 2,1", obs_chan[0], obs_hi[0]); end
    run_scan(6'h12, 0, 1'b0, 1'b0, 1'b0, 4'd0, 28'd0);
    mdl_alarm |= viol_mask(3);
    run_scan(6'h13, 20, 1'b0, 1'b0, 1'b0, 4'd0, 28'd0);
    mdl_alarm |= viol_mask(2);
    n_chk++; if (obs_hi[0] !== 1'b0 || obs_lo[0] !== 1'b0) begin n_fail++; $display("FAIL lwc_new_limit: hi=%b lo=%b want 0,0", obs_hi[0], obs_lo[0]); end
    n_chk++; if (alarm_a !== mdl_alarm) begin n_fail++; $display("FAIL lwc_alarm: got %h want %h", alarm_a, mdl_alarm); end
  endtask

  task automatic test_overrun();
    logic [3:0]  h_chan, c2;
    logic [27:0] h_freq;
    logic        h_lo, h_hi, stable, pv, seen;
    int k, cnt;
    @(negedge clk);
    ss_a = 6'h14; out_ready_a = 1'b0;
    k = 0;
    while (!out_valid_a && k < 20) begin @(negedge clk); k++; end
    n_chk++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL ovr_first_beat: valid=%b want 1", out_valid_a); end
    h_chan = out_chan_a; h_freq = out_freq_a; h_lo = out_lo_a; h_hi = out_hi_a;
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 5) ss_a = 6'h15;
      if (out_valid_a !== 1'b1 || out_chan_a !== h_chan || out_freq_a !== h_freq ||
          out_lo_a !== h_lo || out_hi_a !== h_hi) stable = 1'b0;
    end
    n_chk++; if (stable !== 1'b1) begin n_fail++; $display("FAIL ovr_hold_stable: got %b want 1", stable); end
    n_chk++; if (overrun_a !== 1'b1 || busy_a !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: overrun=%b busy=%b want 1,1", overrun_a, busy_a); end
    n_chk++; if (h_chan !== 4'd3 || h_freq !== mem_a[3]) begin n_fail++; $display("FAIL ovr_beat0: chan=%0d freq=%0d want 3,%0d", h_chan, h_freq, mem_a[3]); end
    out_ready_a = 1'b1; pv = 1'b1; cnt = 0; c2 = 4'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pv) cnt++;
      if (out_valid_a) c2 = out_chan_a;
      pv = out_valid_a;
      if (!busy_a && !out_valid_a) break;
    end
    n_chk++; if (cnt !== 2 || c2 !== 4'd11) begin n_fail++; $display("FAIL ovr_drain: beats=%0d chan=%0d want 2,11", cnt, c2); end
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (out_valid_a || busy_a) seen = 1'b1; end
    out_ready_a = 1'b0;
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL ovr_no_rescan: activity=%b want 0", seen); end
    mdl_alarm |= viol_mask(3);
    n_chk++; if (alarm_a !== mdl_alarm) begin n_fail++; $display("FAIL ovr_alarm: got %h want %h", alarm_a, mdl_alarm); end
    pulse_clr();
    mdl_alarm = '0;
    n_chk++; if (overrun_a !== 1'b0 || alarm_a !== 16'h0) begin n_fail++; $display("FAIL ovr_clear: overrun=%b alarm=%h want 0,0", overrun_a, alarm_a); end
  endtask

  task automatic test_reset_mid_scan();
    int k;
    @(negedge clk); ss_a = 6'h16;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rstwait: valid=%b busy=%b want 0,0", out_valid_a, busy_a); end
    reset = 1'b0; model_reset();
    @(negedge clk); ss_a = 6'h17;
    k = 0;
    while (!out_valid_a && k < 20) begin @(negedge clk); k++; end
    n_chk++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL rstemit_pre: valid=%b want 1", out_valid_a); end
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rstemit: valid=%b busy=%b want 0,0", out_valid_a, busy_a); end
    reset = 1'b0; model_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_no_phantom: busy=%b want 0", busy_a); end
    run_scan(6'h18, 0, 1'b0, 1'b0, 1'b0, 4'd0, 28'd0);
    n_chk++; if (obs_lat !== 4 || obs_chan[0] !== 4'd7 || obs_chan[1] !== 4'd15) begin n_fail++; $display("FAIL rst_rescan: lat=%0d chans=%0d,%0d want 4,7,15", obs_lat, obs_chan[0], obs_chan[1]); end
    n_chk++; if (obs_freq[0] !== mem_a[7] || obs_freq[1] !== mem_a[15]) begin n_fail++; $display("FAIL rst_rescan_freq: got %0d,%0d want %0d,%0d", obs_freq[0], obs_freq[1], mem_a[7], mem_a[15]); end
  endtask

  task automatic test_random();
    logic [5:0] nss;
    int fc, i, stall;
    for (int it = 0; it < 25; it++) begin
      fc = int'(ss_a[2:0]);
      mem_a[fc]     = 28'($urandom_range(1500));
      mem_a[fc + 8] = 28'($urandom_range(1500));
      if ($urandom_range(1) == 1) begin
        i = fc + 8 * int'($urandom_range(1));
        lim_write(1'b0, 4'(i), 28'($urandom_range(800)));
        lim_write(1'b1, 4'(i), 28'($urandom_range(1500, 400)));
      end
      do nss = 6'($urandom_range(63)); while (nss == ss_a);
      stall = int'($urandom_range(70));
      run_scan(nss, stall, 1'b0, 1'b0, 1'b0, 4'd0, 28'd0);
      n_chk++; if (obs_lat !== 4 || obs_stable !== 1'b1) begin n_fail++; $display("FAIL rnd_timing it=%0d: lat=%0d stable=%b want 4,1", it, obs_lat, obs_stable); end
      for (int b = 0; b < 2; b++) begin
        i = b * 8 + fc;
        n_chk++;
        if (obs_chan[b] !== 4'(i) || obs_freq[b] !== mem_a[i] ||
            obs_lo[b] !== (mem_a[i] < mdl_min[i]) || obs_hi[b] !== (mem_a[i] > mdl_max[i])) begin
          n_fail++;
          $display("FAIL rnd_beat it=%0d b=%0d: chan=%0d freq=%0d lo=%b hi=%b want %0d,%0d,%b,%b", it, b,
                   obs_chan[b], obs_freq[b], obs_lo[b], obs_hi[b], i, mem_a[i],
                   mem_a[i] < mdl_min[i], mem_a[i] > mdl_max[i]);
        end
      end
      mdl_alarm |= viol_mask(fc);
      n_chk++; if (alarm_a !== mdl_alarm) begin n_fail++; $display("FAIL rnd_alarm it=%0d: got %h want %h", it, alarm_a, mdl_alarm); end
      if (it % 8 == 7) begin pulse_clr(); mdl_alarm = '0; end
    end
  endtask

  task automatic test_nonpow2_wrap();
    logic [2:0]  c;
    logic [27:0] f;
    logic        got, lo, hi;
    mem_b[5] = 28'd12345;
    @(negedge clk); ss_b = 6'h18;
    got = 1'b0; c = '0; f = '0; lo = 1'b0; hi = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (out_valid_b) begin
        got = 1'b1; c = out_chan_b; f = out_freq_b; lo = out_lo_b; hi = out_hi_b;
        out_ready_b = 1'b1;
      end
    end
    @(negedge clk);
    out_ready_b = 1'b0;
    n_chk++; if (got !== 1'b1 || c !== 3'd5 || f !== 28'd12345) begin n_fail++; $display("FAIL np2_beat: got=%b chan=%0d freq=%0d want 1,5,12345", got, c, f); end
    n_chk++; if (lo !== 1'b0 || hi !== 1'b0) begin n_fail++; $display("FAIL np2_flags: lo=%b hi=%b want 0,0", lo, hi); end
    @(negedge clk);
    n_chk++; if (out_valid_b !== 1'b0 || busy_b !== 1'b0 || alarm_b !== 6'h0 || overrun_b !== 1'b0) begin n_fail++; $display("FAIL np2_idle: valid=%b busy=%b alarm=%h ovr=%b want 0", out_valid_b, busy_b, alarm_b, overrun_b); end
  endtask

  initial begin
    reset = 1'b1;
    ss_a = 6'h05; ss_b = 6'h15;
    lim_we = 1'b0; lim_sel = 1'b0; lim_addr = '0; lim_data = '0;
    out_ready_a = 1'b0; out_ready_b = 1'b0; alarm_clr_a = 1'b0;
    for (int i = 0; i < 16; i++) mem_a[i] = 28'(i * 10);
    for (int i = 0; i < 8; i++)  mem_b[i] = 28'(i * 10);
    model_reset();
    test_reset();
    test_basic();
    test_limits();
    test_lim_write_during_check();
    test_overrun();
    test_reset_mid_scan();
    test_random();
    test_nonpow2_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
